mem_access: RTL

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access_pkg.sv | 46 ++++
 rtl/mem_format.sv | 62 ++++++
 rtl/mem_access.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM-stage load/store unit: memop encoding,
// FSM state encoding, wait-counter sizing and small decode helpers.
package mem_access_pkg;

    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        OP_LB   = 4'd1,
        OP_LBU  = 4'd2,
        OP_LH   = 4'd3,
        OP_LHU  = 4'd4,
        OP_LW   = 4'd5,
        OP_SB   = 4'd6,
        OP_SH   = 4'd7,
        OP_SW   = 4'd8
    } memop_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int TIMEOUT_DEFAULT = 255;
    localparam int CNT_W           = 8;

    function automatic logic is_load(input logic [3:0] op);
        return (op >= OP_LB) && (op <= OP_LW);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op >= OP_SB) && (op <= OP_SW);
    endfunction

    // Encodings 9..15 are not memory ops, so they count as aligned here.
    function automatic logic is_aligned(input logic [3:0] op, input logic [1:0] addr_lo);
        logic ok;
        ok = 1'b1;
        case (op)
            OP_LH, OP_LHU, OP_SH: ok = ~addr_lo[0];
            OP_LW, OP_SW:         ok = (addr_lo == 2'b00);
            default:              ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_format.sv
// Combinational data steering for mem_access: extracts and extends load data
// from the addressed lane, and builds byte enables and replicated store data.
module mem_format
    import mem_access_pkg::*;
(
    input  logic [3:0]  memop,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    input  logic [31:0] sdata,
    output logic [31:0] load_data,
    output logic [3:0]  be,
    output logic [31:0] store_data
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        lane_byte = rdata[7:0];
        case (addr_lo)
            2'd0:    lane_byte = rdata[7:0];
            2'd1:    lane_byte = rdata[15:8];
            2'd2:    lane_byte = rdata[23:16];
            default: lane_byte = rdata[31:24];
        endcase
        lane_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        load_data = rdata;
        case (memop)
            OP_LB:   load_data = {{24{lane_byte[7]}}, lane_byte};
            OP_LBU:  load_data = {24'd0, lane_byte};
            OP_LH:   load_data = {{16{lane_half[15]}}, lane_half};
            OP_LHU:  load_data = {16'd0, lane_half};
            default: load_data = rdata;
        endcase
    end

    // Loads drive the same lane mask as the equivalent store size.
    always_comb begin
        be         = 4'b0000;
        store_data = sdata;
        case (memop)
            OP_LB, OP_LBU, OP_SB: begin
                be         = 4'b0001 << addr_lo;
                store_data = {4{sdata[7:0]}};
            end
            OP_LH, OP_LHU, OP_SH: begin
                be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                store_data = {2{sdata[15:0]}};
            end
            OP_LW, OP_SW: begin
                be         = 4'b1111;
                store_data = sdata;
            end
            default: begin
                be         = 4'b0000;
                store_data = sdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: passes non-memory results straight through and runs a
// single bus transaction per load/store, stalling the pipe until it completes.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [31:0] in_wdata,
    input  logic [4:0]  in_waddr,
    input  logic        in_we,
    input  logic [3:0]  in_memop,
    input  logic [31:0] in_sdata,
    output logic [31:0] wb_wdata,
    output logic [4:0]  wb_waddr,
    output logic        wb_we,
    output logic        stall_req,
    output logic        addr_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    state_e           state;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [31:0]      data_q;
    logic             timed_out_q;

    logic [31:0] fmt_load;
    logic [31:0] fmt_wdata;
    logic [3:0]  fmt_be;

    logic op_load;
    logic op_store;
    logic op_mem;
    logic op_aligned;
    logic start_bus;
    logic misaligned;
    logic timeout_hit;

    mem_format u_format (
        .memop      (in_memop),
        .addr_lo    (in_wdata[1:0]),
        .rdata      (bus_rdata),
        .sdata      (in_sdata),
        .load_data  (fmt_load),
        .be         (fmt_be),
        .store_data (fmt_wdata)
    );

    assign op_load    = is_load(in_memop);
    assign op_store   = is_store(in_memop);
    assign op_mem     = op_load | op_store;
    assign op_aligned = is_aligned(in_memop, in_wdata[1:0]);
    assign start_bus  = (state == IDLE) && op_mem && op_aligned;
    assign misaligned = (state == IDLE) && op_mem && !op_aligned;

    // Saturating increment: the counter must never wrap back to zero.
    assign cnt_inc     = (wait_cnt == {CNT_W{1'b1}}) ? wait_cnt : wait_cnt + 1'b1;
    assign timeout_hit = (cnt_inc == TIMEOUT_CNT);

    // A stalled misaligned op stays in IDLE, so the error is flagged only
    // on the cycle it leaves the stage to keep it a single pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            data_q      <= '0;
            timed_out_q <= 1'b0;
            addr_err    <= 1'b0;
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_be      <= 4'b0000;
            bus_addr    <= '0;
            bus_wdata   <= '0;
        end else begin
            addr_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_bus) begin
                        state       <= BUS;
                        wait_cnt    <= '0;
                        timed_out_q <= 1'b0;
                        bus_req     <= 1'b1;
                        bus_we      <= op_store;
                        bus_be      <= fmt_be;
                        bus_addr    <= {in_wdata[31:2], 2'b00};
                        bus_wdata   <= fmt_wdata;
                    end else if (misaligned && !stall) begin
                        addr_err <= 1'b1;
                    end
                end
                BUS: begin
                    wait_cnt <= cnt_inc;
                    if (bus_ack) begin
                        state   <= DONE;
                        data_q  <= op_load ? fmt_load : 32'd0;
                        bus_req <= 1'b0;
                        bus_we  <= 1'b0;
                        bus_be  <= 4'b0000;
                    end else if (timeout_hit) begin
                        state       <= DONE;
                        data_q      <= 32'd0;
                        timed_out_q <= 1'b1;
                        addr_err    <= 1'b1;
                        bus_req     <= 1'b0;
                        bus_we      <= 1'b0;
                        bus_be      <= 4'b0000;
                    end
                end
                DONE: begin
                    if (!stall) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Writeback mux: pass-through in IDLE, suppressed while the bus is busy,
    // captured load data in DONE.
    always_comb begin
        stall_req = 1'b0;
        wb_wdata  = in_wdata;
        wb_waddr  = in_waddr;
        wb_we     = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    stall_req = start_bus;
                    wb_we     = op_mem ? 1'b0 : in_we;
                end
                BUS: begin
                    stall_req = 1'b1;
                end
                DONE: begin
                    wb_wdata = data_q;
                    wb_we    = op_load && in_we && !timed_out_q;
                end
                default: begin
                    stall_req = 1'b0;
                end
            endcase
        end
    end

endmodule
